// File: rtl/triangle_transformer_if.sv
// Shared Q16.16 geometry types and the triangle stream interface
// (input handshake, output FIFO head, busy) for triangle_transformer.
package triangle_transformer_pkg;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
    } vec3_t;

    typedef struct packed {
        vec3_t pos;
        vec3_t rot_sin;
        vec3_t rot_cos;
        vec3_t scale;
    } transform_t;

    typedef struct packed {
        vec3_t       pos;
        logic [31:0] color;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

endpackage

interface triangle_transformer_if;
    import triangle_transformer_pkg::*;

    transform_t transform;
    triangle_t  triangle;
    logic       in_valid;
    logic       in_ready;
    triangle_t  out_triangle;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    modport master (
        output transform, triangle, in_valid, out_ready,
        input  in_ready, out_triangle, out_valid, busy
    );

    modport slave (
        input  transform, triangle, in_valid, out_ready,
        output in_ready, out_triangle, out_valid, busy
    );

endinterface

// File: rtl/triangle_transformer.sv
// Transforms one triangle at a time by a ZYX rotation pose (Q16.16) into a small output FIFO.
// Optional macro TRANSFORMER_SATURATE_EN clamps each output coordinate instead of wrapping.
module triangle_transformer
    import triangle_transformer_pkg::*;
#(
    parameter int MODE       = 0,
    parameter int FIFO_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    triangle_transformer_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, COEF, VERT, WRITE} state_t;

    state_t             state, state_next;
    logic [1:0]         vcnt;
    transform_t         snap_tf;
    triangle_t          snap_tri;
    triangle_t          res_tri;
    logic signed [31:0] rot [3][3];
    vec3_t              cur_pos;
    logic signed [63:0] src [3];
    logic signed [63:0] dot_next [3];
    logic signed [63:0] off [3];
    logic               vld_p1;
    logic [1:0]         idx_p1;
    logic signed [63:0] dot_p1 [3];
    vertex_t            fin_vtx;
    triangle_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               accept, push, pop;

    function automatic logic signed [63:0] sx64(input logic signed [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic signed [63:0] mul_q(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [63:0] p;
        p = a * b;
        return p >>> 16;
    endfunction

    function automatic logic signed [31:0] mul32(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] p;
        p = mul_q(sx64(a), sx64(b));
        return p[31:0];
    endfunction

    // Full-precision accumulation; the Q16.16 shift happens once on the sum.
    function automatic logic signed [63:0] dot3(input logic signed [31:0] r0, input logic signed [31:0] r1,
                                                input logic signed [31:0] r2, input logic signed [63:0] a,
                                                input logic signed [63:0] b, input logic signed [63:0] c);
        return (sx64(r0) * a + sx64(r1) * b + sx64(r2) * c) >>> 16;
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
`ifdef TRANSFORMER_SATURATE_EN
        if (v > 64'sd2147483647)
            return 32'sh7FFF_FFFF;
        else if (v < -64'sd2147483648)
            return 32'sh8000_0000;
        return v[31:0];
`else
        return v[31:0];
`endif
    endfunction

    function automatic vec3_t get_pos(input triangle_t t, input logic [1:0] i);
        case (i)
            2'd0:    return t.v0.pos;
            2'd1:    return t.v1.pos;
            default: return t.v2.pos;
        endcase
    endfunction

    function automatic logic [31:0] get_color(input triangle_t t, input logic [1:0] i);
        case (i)
            2'd0:    return t.v0.color;
            2'd1:    return t.v1.color;
            default: return t.v2.color;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept = (state == IDLE) && bus.in_valid;
    assign pop    = (count != '0) && bus.out_ready;
    // Wait for the last vertex to leave the pipeline before the triangle is complete.
    assign push   = (state == WRITE) && !vld_p1 && ((count < CNT_W'(FIFO_DEPTH)) || pop);

    assign bus.in_ready     = (state == IDLE);
    assign bus.out_valid    = (count != '0);
    assign bus.out_triangle = mem[rd_ptr];
    assign bus.busy         = (state != IDLE) || (count != '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = COEF;
            COEF:    state_next = VERT;
            VERT:    if (vcnt == 2'd2) state_next = WRITE;
            WRITE:   if (push) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            vcnt  <= '0;
        end else begin
            state <= state_next;
            if (state == COEF)
                vcnt <= '0;
            else if (state == VERT)
                vcnt <= (vcnt == 2'd2) ? 2'd0 : vcnt + 2'd1;
        end
    end

    // Stage p0: source vector for the current vertex and its three dot products
    always_comb begin
        cur_pos = get_pos(snap_tri, vcnt);
        src[0]  = '0;
        src[1]  = '0;
        src[2]  = '0;
        if (MODE == 0) begin
            src[0] = sx64(cur_pos.x - snap_tf.pos.x);
            src[1] = sx64(cur_pos.y - snap_tf.pos.y);
            src[2] = sx64(cur_pos.z - snap_tf.pos.z);
            dot_next[0] = dot3(rot[0][0], rot[1][0], rot[2][0], src[0], src[1], src[2]);
            dot_next[1] = dot3(rot[0][1], rot[1][1], rot[2][1], src[0], src[1], src[2]);
            dot_next[2] = dot3(rot[0][2], rot[1][2], rot[2][2], src[0], src[1], src[2]);
        end else begin
            src[0] = mul_q(sx64(snap_tf.scale.x), sx64(cur_pos.x));
            src[1] = mul_q(sx64(snap_tf.scale.y), sx64(cur_pos.y));
            src[2] = mul_q(sx64(snap_tf.scale.z), sx64(cur_pos.z));
            dot_next[0] = dot3(rot[0][0], rot[0][1], rot[0][2], src[0], src[1], src[2]);
            dot_next[1] = dot3(rot[1][0], rot[1][1], rot[1][2], src[0], src[1], src[2]);
            dot_next[2] = dot3(rot[2][0], rot[2][1], rot[2][2], src[0], src[1], src[2]);
        end
    end

    // Stage p1: translation, clamp or wrap, and color pass-through
    always_comb begin
        off[0]  = (MODE == 1) ? sx64(snap_tf.pos.x) : 64'sd0;
        off[1]  = (MODE == 1) ? sx64(snap_tf.pos.y) : 64'sd0;
        off[2]  = (MODE == 1) ? sx64(snap_tf.pos.z) : 64'sd0;
        fin_vtx = '0;
        fin_vtx.pos.x = sat32(dot_p1[0] + off[0]);
        fin_vtx.pos.y = sat32(dot_p1[1] + off[1]);
        fin_vtx.pos.z = sat32(dot_p1[2] + off[2]);
        fin_vtx.color = get_color(snap_tri, idx_p1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_tf  <= '0;
            snap_tri <= '0;
            res_tri  <= '0;
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            for (int i = 0; i < 3; i++) begin
                dot_p1[i] <= '0;
                for (int j = 0; j < 3; j++)
                    rot[i][j] <= '0;
            end
        end else begin
            if (accept) begin
                snap_tf  <= bus.transform;
                snap_tri <= bus.triangle;
            end
            if (state == COEF) begin
                rot[0][0] <= mul32(snap_tf.rot_cos.z, snap_tf.rot_cos.y);
                rot[0][1] <= mul32(mul32(snap_tf.rot_cos.z, snap_tf.rot_sin.y), snap_tf.rot_sin.x)
                             - mul32(snap_tf.rot_sin.z, snap_tf.rot_cos.x);
                rot[0][2] <= mul32(mul32(snap_tf.rot_cos.z, snap_tf.rot_sin.y), snap_tf.rot_cos.x)
                             + mul32(snap_tf.rot_sin.z, snap_tf.rot_sin.x);
                rot[1][0] <= mul32(snap_tf.rot_sin.z, snap_tf.rot_cos.y);
                rot[1][1] <= mul32(mul32(snap_tf.rot_sin.z, snap_tf.rot_sin.y), snap_tf.rot_sin.x)
                             + mul32(snap_tf.rot_cos.z, snap_tf.rot_cos.x);
                rot[1][2] <= mul32(mul32(snap_tf.rot_sin.z, snap_tf.rot_sin.y), snap_tf.rot_cos.x)
                             - mul32(snap_tf.rot_cos.z, snap_tf.rot_sin.x);
                rot[2][0] <= -snap_tf.rot_sin.y;
                rot[2][1] <= mul32(snap_tf.rot_cos.y, snap_tf.rot_sin.x);
                rot[2][2] <= mul32(snap_tf.rot_cos.y, snap_tf.rot_cos.x);
            end
            vld_p1 <= (state == VERT);
            idx_p1 <= vcnt;
            if (state == VERT) begin
                for (int i = 0; i < 3; i++)
                    dot_p1[i] <= dot_next[i];
            end
            if (vld_p1) begin
                case (idx_p1)
                    2'd0:    res_tri.v0 <= fin_vtx;
                    2'd1:    res_tri.v1 <= fin_vtx;
                    default: res_tri.v2 <= fin_vtx;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= res_tri;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_transformer.sv
// Bench for triangle_transformer: one MODE 0 and one MODE 1 instance, vector table
// with a scoreboard queue per instance, plus latency/backpressure/reset sequences.
module tb_triangle_transformer;
    import triangle_transformer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    triangle_transformer_if bus0();
    triangle_transformer_if bus1();

    triangle_transformer #(.MODE(0), .FIFO_DEPTH(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    triangle_transformer #(.MODE(1), .FIFO_DEPTH(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        int         mode;
        string      name;
        transform_t tf;
        triangle_t  t;
        triangle_t  want;
    } vec_t;

    vec_t      vecs[$];
    triangle_t sb0[$];
    triangle_t sb1[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic signed [31:0] q(input real r);
        return $rtoi(r * 65536.0);
    endfunction

    function automatic vec3_t v3(input real x, input real y, input real z);
        vec3_t v;
        v.x = q(x); v.y = q(y); v.z = q(z);
        return v;
    endfunction

    function automatic vec3_t v3r(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        vec3_t v;
        v.x = x; v.y = y; v.z = z;
        return v;
    endfunction

    function automatic vertex_t vx(input vec3_t p, input logic [31:0] c);
        vertex_t v;
        v.pos = p; v.color = c;
        return v;
    endfunction

    function automatic triangle_t mk_tri(input vertex_t a, input vertex_t b, input vertex_t c);
        triangle_t t;
        t.v0 = a; t.v1 = b; t.v2 = c;
        return t;
    endfunction

    function automatic transform_t mk_tf(input vec3_t pos, input vec3_t sn, input vec3_t cs, input vec3_t sc);
        transform_t f;
        f.pos = pos; f.rot_sin = sn; f.rot_cos = cs; f.scale = sc;
        return f;
    endfunction

    task automatic check_tri(input string name, input triangle_t act, input triangle_t want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, want);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, want);
        end
    endtask

    task automatic add_vec(input int mode, input string name, input transform_t tf,
                           input triangle_t t, input triangle_t want);
        vec_t v;
        v.mode = mode; v.name = name; v.tf = tf; v.t = t; v.want = want;
        vecs.push_back(v);
    endtask

    // Scoreboard: every accepted output transfer is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus0.out_valid && bus0.out_ready) begin
            if (sb0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL out0_unexpected actual=%h required=no_output", bus0.out_triangle);
            end else
                check_tri("out0", bus0.out_triangle, sb0.pop_front());
        end
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            if (sb1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL out1_unexpected actual=%h required=no_output", bus1.out_triangle);
            end else
                check_tri("out1", bus1.out_triangle, sb1.pop_front());
        end
    end

    task automatic send(input int which, input transform_t tf, input triangle_t t);
        int guard;
        guard = 0;
        if (which == 0) begin
            bus0.transform = tf; bus0.triangle = t; bus0.in_valid = 1'b1;
        end else begin
            bus1.transform = tf; bus1.triangle = t; bus1.in_valid = 1'b1;
        end
        @(negedge clk);
        while (!((which == 0) ? bus0.in_ready : bus1.in_ready) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || bus0.busy || bus1.busy) && g < 400) begin
            @(negedge clk);
            g++;
        end
        check_int(name, (g < 400) ? 1 : 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        transform_t id_tf, tf_b;
        triangle_t  t0, w0, tk, wk;
        int         xfer, g;
        logic [31:0] sat_pos, sat_neg;

`ifdef TRANSFORMER_SATURATE_EN
        sat_pos = 32'h7FFF_FFFF;
        sat_neg = 32'h8000_0000;
`else
        sat_pos = 32'hFFFE_0000;
        sat_neg = 32'h0002_0000;
`endif

        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.transform = '0; bus0.triangle = '0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.transform = '0; bus1.triangle = '0;

        id_tf = mk_tf(v3(1, 2, 3), v3(0, 0, 0), v3(1, 1, 1), v3(1, 1, 1));
        t0 = mk_tri(vx(v3(5, 5, 5), 32'h11), vx(v3(0, 0, 0), 32'h22), vx(v3(1, 2, 3), 32'h33));
        w0 = mk_tri(vx(v3(4, 3, 2), 32'h11), vx(v3(-1, -2, -3), 32'h22), vx(v3(0, 0, 0), 32'h33));
        add_vec(0, "m0_translate", id_tf, t0, w0);

        add_vec(0, "m0_rotz90",
                mk_tf(v3(0, 0, 0), v3(0, 0, 1), v3(1, 1, 0), v3(1, 1, 1)),
                mk_tri(vx(v3(1, 0, 0), 32'hABCDEF), vx(v3(0, 1, 0), 32'h1), vx(v3(0, 0, 2), 32'hFFFF_FFFF)),
                mk_tri(vx(v3r(0, 32'hFFFF_0000, 0), 32'hABCDEF), vx(v3(1, 0, 0), 32'h1),
                       vx(v3(0, 0, 2), 32'hFFFF_FFFF)));

        add_vec(1, "m1_scale_translate",
                mk_tf(v3(10, 0, 0), v3(0, 0, 0), v3(1, 1, 1), v3(2, 2, 2)),
                mk_tri(vx(v3(1, 1, 1), 32'h44), vx(v3(0, 0, 0), 32'h55), vx(v3(-1, 3, 0.5), 32'h66)),
                mk_tri(vx(v3(12, 2, 2), 32'h44), vx(v3(10, 0, 0), 32'h55), vx(v3(8, 6, 1), 32'h66)));

        add_vec(1, "m1_rotz90",
                mk_tf(v3(0, 0, 5), v3(0, 0, 1), v3(1, 1, 0), v3(1, 1, 1)),
                mk_tri(vx(v3(1, 0, 0), 32'h7), vx(v3(0, 1, 0), 32'h8), vx(v3(0, 0, 1), 32'h9)),
                mk_tri(vx(v3(0, 1, 5), 32'h7), vx(v3(-1, 0, 5), 32'h8), vx(v3(0, 0, 6), 32'h9)));

        add_vec(1, "m1_overflow_floor",
                mk_tf(v3(0, 0, 0), v3(0, 0, 0), v3(1, 1, 1), v3r(32'h7FFF_0000, 32'h0001_8000, 32'h0001_0000)),
                mk_tri(vx(v3(2, 0, 0), 32'hA), vx(v3r(0, 32'hFFFF_FFFF, 0), 32'hB), vx(v3(-2, 0, 0), 32'hC)),
                mk_tri(vx(v3r(sat_pos, 0, 0), 32'hA), vx(v3r(0, 32'hFFFF_FFFE, 0), 32'hB),
                       vx(v3r(sat_neg, 0, 0), 32'hC)));

        add_vec(0, "m0_sub_wrap",
                mk_tf(v3r(32'hFFFE_0000, 0, 0), v3(0, 0, 0), v3(1, 1, 1), v3(1, 1, 1)),
                mk_tri(vx(v3r(32'h7FFF_0000, 0, 0), 32'hD), vx(v3(0, 0, 0), 32'hE), vx(v3(1, 1, 1), 32'hF)),
                mk_tri(vx(v3r(32'h8001_0000, 0, 0), 32'hD), vx(v3(2, 0, 0), 32'hE), vx(v3(3, 1, 1), 32'hF)));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_int("rst_out_valid0", int'(bus0.out_valid), 0);
        check_int("rst_busy0", int'(bus0.busy), 0);
        check_tri("rst_out_triangle0", bus0.out_triangle, '0);
        check_int("rst_out_valid1", int'(bus1.out_valid), 0);
        check_int("rst_busy1", int'(bus1.busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check_int("post_rst_in_ready0", int'(bus0.in_ready), 1);
        check_int("post_rst_in_ready1", int'(bus1.in_ready), 1);
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].mode == 0) sb0.push_back(vecs[i].want);
            else                   sb1.push_back(vecs[i].want);
            send(vecs[i].mode, vecs[i].tf, vecs[i].t);
            drain({"drain_", vecs[i].name});
            @(posedge clk);
            #1;
        end

        // Latency with an empty FIFO
        sb0.push_back(w0);
        send(0, id_tf, t0);
        xfer = cyc;
        g = 0;
        @(negedge clk);
        while (!bus0.out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_int("latency", cyc - xfer, 6);
        drain("drain_latency");
        @(posedge clk);
        #1;

        // Transform changed right after acceptance must not affect the triangle
        sb0.push_back(w0);
        send(0, id_tf, t0);
        tf_b = mk_tf(v3(100, -7, 3), v3(0, 0, 1), v3(1, 1, 0), v3(3, 3, 3));
        bus0.transform = tf_b;
        drain("drain_tf_change");
        @(posedge clk);
        #1;

        // Backpressure: two queued, third held in WRITE, fourth waits
        bus0.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tk = mk_tri(vx(v3(k, k, k), 32'(k)), vx(v3(k, 0, 0), 32'(k + 16)), vx(v3(0, 0, k), 32'(k + 32)));
            wk = mk_tri(vx(v3(k - 1, k - 2, k - 3), 32'(k)), vx(v3(k - 1, -2, -3), 32'(k + 16)),
                        vx(v3(-1, -2, k - 3), 32'(k + 32)));
            if (k == 4) begin
                repeat (10) @(negedge clk);
                check_int("bp_out_valid", int'(bus0.out_valid), 1);
                check_int("bp_in_ready_held", int'(bus0.in_ready), 0);
                check_int("bp_busy", int'(bus0.busy), 1);
                bus0.transform = id_tf; bus0.triangle = tk; bus0.in_valid = 1'b1;
                repeat (3) @(negedge clk);
                check_int("bp_fourth_blocked", int'(bus0.in_ready), 0);
                @(posedge clk);
                #1;
                bus0.out_ready = 1'b1;
            end
            sb0.push_back(wk);
            send(0, id_tf, tk);
        end
        drain("drain_backpressure");
        @(posedge clk);
        #1;

        // Reset while processing vertices drops the triangle
        send(0, id_tf, t0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_int("vert_rst_out_valid", int'(bus0.out_valid), 0);
        check_int("vert_rst_busy", int'(bus0.busy), 0);
        check_int("vert_rst_in_ready", int'(bus0.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_int("after_rst_out_valid", int'(bus0.out_valid), 0);
        check_int("after_rst_busy", int'(bus0.busy), 0);

        drain("drain_final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
